// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: credit-limited imem requests, in-order fill ring buffer, decode-side output.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned PC allocates a faulting NOP entry instead of a memory request.
module if_fetch_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_address_i,
  output logic        pc_enable_o,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        flush_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        inst_fault_o,
`endif
  input  logic        inst_ready_i
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int PTRW = PW + 1;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
`endif
  typedef logic [PTRW-1:0] ptr_t;

  logic [31:0]           pc_q   [FIFO_DEPTH];
  logic [31:0]           pc_d   [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [31:0]           data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] filled_q, filled_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic [FIFO_DEPTH-1:0] fault_q, fault_d;
`endif
  ptr_t alloc_ptr_q, alloc_ptr_d;
  ptr_t fill_ptr_q, fill_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t drop_cnt_q, drop_cnt_d;
  ptr_t inflight;
  logic [PTRW:0] used;
  logic credit_ok, misalign, req_hs, fault_alloc;
  logic [PW-1:0] rd_idx, fill_idx, alloc_idx;

  assign rd_idx    = rd_ptr_q[PW-1:0];
  assign fill_idx  = fill_ptr_q[PW-1:0];
  assign alloc_idx = alloc_ptr_q[PW-1:0];

  // Discarded responses still owed by memory count against credit.
  always_comb begin
    used             = {1'b0, ptr_t'(alloc_ptr_q - rd_ptr_q)} + {1'b0, drop_cnt_q};
    credit_ok        = rst_n && !flush_i && (used < (PTRW+1)'(FIFO_DEPTH));
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign         = pc_address_i[1:0] != 2'b00;
`else
    misalign         = 1'b0;
`endif
    imem_req_valid_o = credit_ok && !misalign;
    imem_req_addr_o  = {pc_address_i[31:2], 2'b00};
    req_hs           = imem_req_valid_o && imem_req_ready_i;
    fault_alloc      = credit_ok && misalign;
    pc_enable_o      = req_hs || fault_alloc;
    inst_valid_o     = filled_q[rd_idx] && (rd_ptr_q != alloc_ptr_q);
    inst_o           = data_q[rd_idx];
    inst_pc_o        = pc_q[rd_idx];
`ifdef FETCH_MISALIGN_CHECK_EN
    inst_fault_o     = inst_valid_o && fault_q[rd_idx];
`endif
  end

  // Requests still owed by memory; fault entries never get a response.
  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    inflight = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ptr_t'(i) < ptr_t'(alloc_ptr_q - fill_ptr_q) && !fault_q[fill_idx + PW'(i)])
        inflight = inflight + ptr_t'(1);
    end
`else
    inflight = alloc_ptr_q - fill_ptr_q;
`endif
  end

  always_comb begin
    pc_d        = pc_q;
    data_d      = data_q;
    filled_d    = filled_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d     = fault_q;
`endif
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    drop_cnt_d  = drop_cnt_q;
    if (flush_i) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
      filled_d    = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_d     = '0;
`endif
      drop_cnt_d  = drop_cnt_q + inflight;
      if (imem_rsp_valid_i && drop_cnt_d != '0)
        drop_cnt_d = drop_cnt_d - ptr_t'(1);
    end else begin
      if (inst_valid_o && inst_ready_i) begin
        filled_d[rd_idx] = 1'b0;
        rd_ptr_d         = rd_ptr_q + ptr_t'(1);
      end
      // A response with nothing owed is a protocol violation and is ignored.
      if (imem_rsp_valid_i) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - ptr_t'(1);
        end else if (fill_ptr_q != alloc_ptr_q) begin
          data_d[fill_idx]   = imem_rsp_data_i;
          filled_d[fill_idx] = 1'b1;
          fill_ptr_d         = fill_ptr_q + ptr_t'(1);
        end
      end
      if (pc_enable_o) begin
        pc_d[alloc_idx]     = pc_address_i;
        filled_d[alloc_idx] = fault_alloc;
        alloc_ptr_d         = alloc_ptr_q + ptr_t'(1);
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d[alloc_idx]  = fault_alloc;
        if (fault_alloc)
          data_d[alloc_idx] = NOP;
`endif
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (fill_ptr_d != alloc_ptr_d && fault_d[fill_ptr_d[PW-1:0]])
          fill_ptr_d = fill_ptr_d + ptr_t'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
      filled_q    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q     <= '0;
`endif
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      data_q      <= data_d;
      filled_q    <= filled_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q     <= fault_d;
`endif
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
